// File: rtl/uart_pkg.sv
// uart_pkg: constants and FSM state type shared by the FMB UART transmitter
// and receiver.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS    = 8;
   // 21.74 MHz system clock / 115200 baud
   localparam int unsigned UART_CLKS_PER_BIT = 189;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous board input.
// The reset value is a parameter so idle-high lines can be preset high.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with mid-bit sampling, 8N1 frames by default.
// Define UART_RX_PARITY_EN to build the 8E1 variant with a live parity_err.
// Received bytes are held in a valid/ack register with frame/parity status;
// a byte completing while the register is still full is dropped and
// signalled by a one-cycle overrun pulse.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ser_in,
   input  logic                      rx_ack,
   output logic [UART_DATA_BITS-1:0] rx_data,
   output logic                      rx_valid,
   output logic                      frame_err,
   output logic                      parity_err,
   output logic                      overrun,
   output logic                      rx_busy
);

   localparam int unsigned        CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]   BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]   HALF_BIT     = CNT_W'(CLKS_PER_BIT / 2);
   localparam int unsigned        BCNT_W       = $clog2(UART_DATA_BITS);
   localparam logic [BCNT_W-1:0]  BIT_IDX_LAST = BCNT_W'(UART_DATA_BITS - 1);

   logic                      rxs;
   rx_state_t                 state;
   logic [CNT_W-1:0]          baud_cnt;
   logic [BCNT_W-1:0]         bit_cnt;
   logic [UART_DATA_BITS-1:0] shreg;
   logic                      bit_tick;
   logic                      half_tick;
   logic                      byte_done;
   logic                      par_flag;

   uart_sync2 #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst),
      .d     (ser_in),
      .q     (rxs)
   );

   assign bit_tick  = (baud_cnt == BIT_LAST);
   assign half_tick = (baud_cnt == HALF_BIT);
   assign byte_done = (state == STOP) && bit_tick;
   assign rx_busy   = (state != IDLE);

`ifdef UART_RX_PARITY_EN
   logic par_bad;

   // Even-parity check of the received byte against the parity bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         par_bad <= 1'b0;
      end else if ((state == PARITY) && bit_tick) begin
         par_bad <= (^shreg) ^ rxs;
      end
   end

   assign par_flag = par_bad;
`else
   assign par_flag = 1'b0;
`endif

   // Frame sequencing: start qualification, data/parity/stop sampling.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else begin
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               if (!rxs) begin
                  state   <= START;
                  bit_cnt <= '0;
               end
            end
            START: begin
               if (half_tick) begin
                  baud_cnt <= '0;
                  state    <= rxs ? IDLE : DATA;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (bit_tick) begin
                  baud_cnt <= '0;
                  shreg    <= {rxs, shreg[UART_DATA_BITS-1:1]};
                  bit_cnt  <= bit_cnt + BCNT_W'(1);
                  if (bit_cnt == BIT_IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (bit_tick) begin
                  baud_cnt <= '0;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
`endif
            STOP: begin
               if (bit_tick) begin
                  baud_cnt <= '0;
                  state    <= rxs ? IDLE : WAIT_IDLE;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            WAIT_IDLE: begin
               baud_cnt <= '0;
               if (rxs) begin
                  state <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               baud_cnt <= '0;
            end
         endcase
      end
   end

   // Holding register: load on completion when free or acked, else overrun.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (byte_done) begin
            if (!rx_valid || rx_ack) begin
               rx_data    <= shreg;
               frame_err  <= ~rxs;
               parity_err <= par_flag;
               rx_valid   <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ack) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a frame-level model.
// Expected bytes and overrun pulses are queued with the clock at which they
// must appear; an independent monitor checks them as the DUT presents them.
// Define UART_RX_PARITY_EN for both bench and RTL to exercise 8E1.
module tb_uart_rx;

   localparam int unsigned N = 16;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned L = 3 + N / 2 + 10 * N;
`else
   localparam int unsigned L = 3 + N / 2 + 9 * N;
`endif

   logic       clk;
   logic       rst;
   logic       ser_in;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       parity_err;
   logic       overrun;
   logic       rx_busy;

   typedef struct {
      logic [7:0]  d;
      logic        fe;
      logic        pe;
      int unsigned due;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned ovr_q[$];
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   bit          auto_ack = 1'b1;
   int unsigned ack_at = 0;
   logic        last_ack = 1'b0;
   logic        last_valid = 1'b0;

   uart_rx #(
      .CLKS_PER_BIT (N)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ser_in     (ser_in),
      .rx_ack     (rx_ack),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun),
      .rx_busy    (rx_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Consumer: auto-ack one cycle after valid, or ack at a scheduled edge.
   initial begin
      rx_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (cyc + 1 == ack_at)                  rx_ack = 1'b1;
         else if (auto_ack && rx_valid && !rx_ack) rx_ack = 1'b1;
         else                                    rx_ack = 1'b0;
      end
   end

   // Monitor: compare every presented byte and overrun pulse with the queues.
   always @(negedge clk) begin
      logic pres;
      exp_t e;
      pres = rx_valid && (!last_valid || last_ack);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         check("present", {31'd0, pres}, 32'd1);
         check("rx_data", {24'd0, rx_data}, {24'd0, e.d});
         check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
         check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
      end else if (pres) begin
         fail_now("unexpected_byte", {24'd0, rx_data}, 32'd0);
      end else if (last_ack && last_valid) begin
         check("ack_clear", {31'd0, rx_valid}, 32'd0);
      end
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
         e = exp_q.pop_front();
         fail_now("missed_byte", 32'd0, {24'd0, e.d});
      end
      if (overrun) begin
         if (ovr_q.size() > 0 && ovr_q[0] == cyc) begin
            void'(ovr_q.pop_front());
            check("overrun", {31'd0, overrun}, 32'd1);
         end else begin
            fail_now("unexpected_overrun", {31'd0, overrun}, 32'd0);
         end
      end
      while (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
         void'(ovr_q.pop_front());
         fail_now("missed_overrun", 32'd0, 32'd1);
      end
      last_ack   = rx_ack;
      last_valid = rx_valid;
   end

   // mode 0: byte is presented; mode 1: byte dropped with overrun.
   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                             input int mode);
      exp_t        e;
      int unsigned start;
      start = cyc + 1;
      e.d   = d;
      e.fe  = ~stop_b;
`ifdef UART_RX_PARITY_EN
      e.pe  = (^d) ^ par_b;
`else
      e.pe  = 1'b0;
`endif
      e.due = start + L;
      if (mode == 0) exp_q.push_back(e);
      else           ovr_q.push_back(start + L);
      ser_in = 1'b0;
      repeat (N) tick();
      for (int i = 0; i < 8; i++) begin
         ser_in = d[i];
         repeat (N) tick();
      end
`ifdef UART_RX_PARITY_EN
      ser_in = par_b;
      repeat (N) tick();
`endif
      ser_in = stop_b;
      repeat (N) tick();
      ser_in = 1'b1;
   endtask

   function automatic logic even_par(input logic [7:0] d);
      return ^d;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned s1;
      logic        prev_stop;
      logic [7:0]  rd;
      logic        rs;
      logic        rp;
      rst    = 1'b0;
      ser_in = 1'b1;
      repeat (3) tick();
      check("rst_rx_data", {24'd0, rx_data}, 32'd0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_parity_err", {31'd0, parity_err}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
      rst = 1'b1;
      repeat (4) tick();

      send_frame(8'hA5, 1'b1, even_par(8'hA5), 0);
      repeat (8) tick();

      // Short low glitch on an idle line
      ser_in = 1'b0;
      tick();
      tick();
      check("busy_before_rise", {31'd0, rx_busy}, 32'd0);
      tick();
      check("busy_rise", {31'd0, rx_busy}, 32'd1);
      tick();
      tick();
      ser_in = 1'b1;
      repeat (20) tick();
      check("glitch_idle", {31'd0, rx_busy}, 32'd0);
      send_frame(8'h3C, 1'b1, even_par(8'h3C), 0);
      repeat (4) tick();

      // Frame error followed by a long break
      send_frame(8'h00, 1'b0, 1'b0, 0);
      ser_in = 1'b0;
      repeat (40 * N) tick();
      check("wait_idle_busy", {31'd0, rx_busy}, 32'd1);
      ser_in = 1'b1;
      repeat (4) tick();
      check("wait_idle_exit", {31'd0, rx_busy}, 32'd0);
      send_frame(8'h81, 1'b1, even_par(8'h81), 0);
      repeat (4) tick();

      // Back-to-back without ack: second byte dropped
      auto_ack = 1'b0;
      send_frame(8'h11, 1'b1, even_par(8'h11), 0);
      send_frame(8'h22, 1'b1, even_par(8'h22), 1);
      tick();
      check("overrun_keep_data", {24'd0, rx_data}, 32'h11);
      check("overrun_keep_valid", {31'd0, rx_valid}, 32'd1);
      ack_at = cyc + 2;
      repeat (4) tick();

      // Back-to-back with ack in the stop-sample cycle: second byte loaded
      s1     = cyc + 1;
      ack_at = s1 + 10 * N + L;
      send_frame(8'h11, 1'b1, even_par(8'h11), 0);
      send_frame(8'h22, 1'b1, even_par(8'h22), 0);
      tick();
      check("reload_data", {24'd0, rx_data}, 32'h22);
      check("reload_valid", {31'd0, rx_valid}, 32'd1);
      ack_at = cyc + 2;
      repeat (4) tick();
      auto_ack = 1'b1;

      // Reset during data bit 4 of 0xFF
      ser_in = 1'b0;
      repeat (N) tick();
      for (int i = 0; i < 4; i++) begin
         ser_in = 1'b1;
         repeat (N) tick();
      end
      repeat (N / 2) tick();
      rst = 1'b0;
      #1;
      check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
      check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("midrst_rx_busy", {31'd0, rx_busy}, 32'd0);
      check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
      tick();
      ser_in = 1'b1;
      tick();
      rst = 1'b1;
      repeat (2 * N) tick();
      send_frame(8'h5A, 1'b1, even_par(8'h5A), 0);
      repeat (4) tick();

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1, 0);
      repeat (4) tick();
      send_frame(8'h07, 1'b1, 1'b0, 0);
      repeat (4) tick();
`endif

      // Random frames, occasional bad stop bit, random idle gaps
      prev_stop = 1'b1;
      for (int k = 0; k < 12; k++) begin
         rd = 8'($urandom);
         rs = ($urandom_range(0, 4) != 0);
         rp = 1'($urandom);
         if (!prev_stop) repeat (N) tick();
         else            repeat ($urandom_range(0, N)) tick();
         send_frame(rd, rs, rp, 0);
         prev_stop = rs;
      end
      repeat (3 * N) tick();

      check("pending_bytes", exp_q.size(), 32'd0);
      check("pending_overruns", ovr_q.size(), 32'd0);
      check("final_busy", {31'd0, rx_busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
